// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS main controller: FETCH/DECODE/EXECUTE/MEM/WB sequencing with memory stalls and a retired-instruction counter.
// Optional jump support is enabled by defining MCU_JUMP_EN.
module multicycle_control_unit #(
  parameter int OPCODE_W = 6,
  parameter int ALUOP_W  = 2,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                PCWrite,
  output logic                PCWriteCond,
  output logic                IorD,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                IRWrite,
  output logic                MemtoReg,
  output logic                RegDst,
  output logic                RegWrite,
  output logic                AluSrcA,
  output logic [1:0]          AluSrcB,
  output logic [ALUOP_W-1:0]  AluOp,
  output logic [1:0]          PCSource,
  output logic                illegal_op,
  output logic [CNT_W-1:0]    instr_count,
  output logic [3:0]          state
);

  localparam logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'(6'b000000);
  localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(6'b100011);
  localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(6'b101011);
  localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(6'b000100);
`ifdef MCU_JUMP_EN
  localparam logic [OPCODE_W-1:0] OP_J     = OPCODE_W'(6'b000010);
`endif

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_RWB    = 4'd8,
    S_BRANCH = 4'd9
`ifdef MCU_JUMP_EN
    , S_JUMP = 4'd10
`endif
  } state_t;

  typedef struct packed {
    logic               pc_write;
    logic               pc_write_cond;
    logic               iord;
    logic               mem_read;
    logic               mem_write;
    logic               mem_to_reg;
    logic               reg_dst;
    logic               reg_write;
    logic               alu_src_a;
    logic [1:0]         alu_src_b;
    logic [ALUOP_W-1:0] alu_op;
    logic [1:0]         pc_source;
  } ctrl_t;

  state_t           state_r;
  state_t           next_s;
  ctrl_t            ctrl_r;
  logic [CNT_W-1:0] instr_count_r;
  logic             retire_s;
  logic             fetch_ack_s;

  function automatic logic opcode_legal(input logic [OPCODE_W-1:0] op);
    logic ok;
    ok = (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ);
`ifdef MCU_JUMP_EN
    ok = ok || (op == OP_J);
`endif
    return ok;
  endfunction

  // Moore control word for each state; FETCH's IRWrite/PCWrite are added outside.
  function automatic ctrl_t decode_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = 2'b01;
      end
      S_DECODE: c.alu_src_b = 2'b11;
      S_MEMADR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      S_MEMWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      S_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = ALUOP_W'(2'b10);
      end
      S_RWB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = ALUOP_W'(2'b01);
        c.pc_write_cond = 1'b1;
        c.pc_source     = 2'b01;
      end
`ifdef MCU_JUMP_EN
      S_JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = 2'b10;
      end
`endif
      default: c = '0;
    endcase
    return c;
  endfunction

  // Next-state selection from current state, IR opcode and memory handshake.
  always_comb begin
    next_s = S_FETCH;
    case (state_r)
      S_IDLE:   next_s = S_FETCH;
      S_FETCH:  next_s = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (opcode == OP_RTYPE) begin
          next_s = S_EXEC;
        end else if ((opcode == OP_LW) || (opcode == OP_SW)) begin
          next_s = S_MEMADR;
        end else if (opcode == OP_BEQ) begin
          next_s = S_BRANCH;
`ifdef MCU_JUMP_EN
        end else if (opcode == OP_J) begin
          next_s = S_JUMP;
`endif
        end else begin
          next_s = S_FETCH;
        end
      end
      S_MEMADR: begin
        if (opcode == OP_LW) begin
          next_s = S_MEMRD;
        end else if (opcode == OP_SW) begin
          next_s = S_MEMWR;
        end else begin
          next_s = S_FETCH;
        end
      end
      S_MEMRD:  next_s = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  next_s = S_FETCH;
      S_MEMWR:  next_s = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   next_s = S_RWB;
      S_RWB:    next_s = S_FETCH;
      S_BRANCH: next_s = S_FETCH;
`ifdef MCU_JUMP_EN
      S_JUMP:   next_s = S_FETCH;
`endif
      default:  next_s = S_FETCH;
    endcase
  end

  // An instruction retires on its last cycle; a stalled store only once memory accepts it.
  always_comb begin
    retire_s = 1'b0;
    case (state_r)
      S_MEMWB, S_RWB, S_BRANCH: retire_s = 1'b1;
      S_MEMWR:                  retire_s = mem_ready;
`ifdef MCU_JUMP_EN
      S_JUMP:                   retire_s = 1'b1;
`endif
      default:                  retire_s = 1'b0;
    endcase
  end

  // State, control word (decoded from the next state so it lines up with it) and counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= S_IDLE;
      ctrl_r        <= '0;
      instr_count_r <= '0;
    end else begin
      state_r <= next_s;
      ctrl_r  <= decode_ctrl(next_s);
      if (retire_s) begin
        instr_count_r <= instr_count_r + CNT_W'(1);
      end else begin
        instr_count_r <= instr_count_r;
      end
    end
  end

  assign fetch_ack_s = (state_r == S_FETCH) && mem_ready;

  assign PCWrite     = ctrl_r.pc_write | fetch_ack_s;
  assign IRWrite     = fetch_ack_s;
  assign PCWriteCond = ctrl_r.pc_write_cond;
  assign IorD        = ctrl_r.iord;
  assign MemRead     = ctrl_r.mem_read;
  assign MemWrite    = ctrl_r.mem_write;
  assign MemtoReg    = ctrl_r.mem_to_reg;
  assign RegDst      = ctrl_r.reg_dst;
  assign RegWrite    = ctrl_r.reg_write;
  assign AluSrcA     = ctrl_r.alu_src_a;
  assign AluSrcB     = ctrl_r.alu_src_b;
  assign AluOp       = ctrl_r.alu_op;
  assign PCSource    = ctrl_r.pc_source;
  assign illegal_op  = (state_r == S_DECODE) && !opcode_legal(opcode);
  assign instr_count = instr_count_r;
  assign state       = state_r;

  // The branch compare result is applied by the datapath through PCWriteCond.
  logic unused_s;
  assign unused_s = zero;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: directed vector table, reset-abort sequence and randomized instruction stream.
module tb_multicycle_control_unit;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [5:0]       opcode;
  logic             zero;
  logic             mem_ready;
  logic             PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic             MemtoReg, RegDst, RegWrite, AluSrcA, illegal_op;
  logic [1:0]       AluSrcB, AluOp, PCSource;
  logic [CNT_W-1:0] instr_count;
  logic [3:0]       state;

  int               checks = 0;
  int               errors = 0;
  logic [CNT_W-1:0] model_cnt;

  multicycle_control_unit #(.OPCODE_W(6), .ALUOP_W(2), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
    .RegWrite(RegWrite), .AluSrcA(AluSrcA), .AluSrcB(AluSrcB), .AluOp(AluOp),
    .PCSource(PCSource), .illegal_op(illegal_op), .instr_count(instr_count), .state(state)
  );

  always #5 clk = ~clk;

  logic [16:0] ctrl_v;
  assign ctrl_v = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                   RegDst, RegWrite, AluSrcA, AluSrcB, AluOp, PCSource, illegal_op};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

`ifdef MCU_JUMP_EN
  localparam bit JUMP_EN = 1'b1;
`else
  localparam bit JUMP_EN = 1'b0;
`endif

  function automatic bit legal(input logic [5:0] op);
    return (op == 6'b000000) || (op == 6'b100011) || (op == 6'b101011) ||
           (op == 6'b000100) || (JUMP_EN && (op == 6'b000010));
  endfunction

  function automatic int base_cpi(input logic [5:0] op);
    if (op == 6'b000000) return 4;
    if (op == 6'b100011) return 5;
    if (op == 6'b101011) return 4;
    if (op == 6'b000100) return 3;
    if (JUMP_EN && (op == 6'b000010)) return 3;
    return 2;
  endfunction

  // Control table straight from the state descriptions: phase code, mem_ready, opcode -> outputs.
  function automatic logic [16:0] exp_ctrl(input int p, input logic mr, input logic [5:0] op);
    logic pw, pwc, iord, mrd, mwr, irw, m2r, rd, rw, asa, ill;
    logic [1:0] asb, aop, pcs;
    {pw, pwc, iord, mrd, mwr, irw, m2r, rd, rw, asa, ill} = 11'b0;
    asb = 2'b00; aop = 2'b00; pcs = 2'b00;
    case (p)
      1:  begin mrd = 1'b1; asb = 2'b01; pw = mr; irw = mr; end
      2:  begin asb = 2'b11; ill = !legal(op); end
      3:  begin asa = 1'b1; asb = 2'b10; end
      4:  begin mrd = 1'b1; iord = 1'b1; end
      5:  begin rw = 1'b1; m2r = 1'b1; end
      6:  begin mwr = 1'b1; iord = 1'b1; end
      7:  begin asa = 1'b1; aop = 2'b10; end
      8:  begin rw = 1'b1; rd = 1'b1; end
      9:  begin asa = 1'b1; aop = 2'b01; pwc = 1'b1; pcs = 2'b01; end
      10: begin pw = 1'b1; pcs = 2'b10; end
      default: ;
    endcase
    return {pw, pwc, iord, mrd, mwr, irw, m2r, rd, rw, asa, asb, aop, pcs, ill};
  endfunction

  // Runs one instruction from its first FETCH cycle; fs/ms < 0 means random stall count.
  task automatic run_instr(input logic [5:0] op, input int fs, input int ms,
                           output int cyc, output int stall_sum);
    int ph[$];
    int p, stalls, k;
    bit waitp;
    ph = {1, 2};
    if (op == 6'b000000) begin ph.push_back(7); ph.push_back(8); end
    else if (op == 6'b100011) begin ph.push_back(3); ph.push_back(4); ph.push_back(5); end
    else if (op == 6'b101011) begin ph.push_back(3); ph.push_back(6); end
    else if (op == 6'b000100) ph.push_back(9);
    else if (JUMP_EN && (op == 6'b000010)) ph.push_back(10);
    cyc = 0;
    stall_sum = 0;
    opcode = op;
    check("count_at_fetch", 32'(instr_count), 32'(model_cnt));
    foreach (ph[i]) begin
      p = ph[i];
      waitp = (p == 1) || (p == 4) || (p == 6);
      stalls = 0;
      if (waitp) begin
        stalls = (p == 1) ? fs : ms;
        if (stalls < 0) stalls = $urandom_range(0, 2);
      end
      stall_sum += stalls;
      k = 0;
      do begin
        mem_ready = waitp ? (k >= stalls) : 1'($urandom_range(0, 1));
        zero = 1'($urandom_range(0, 1));
        @(negedge clk);
        check("state", 32'(state), 32'(p));
        check("ctrl", 32'(ctrl_v), 32'(exp_ctrl(p, mem_ready, op)));
        @(posedge clk);
        #1;
        cyc++;
        k++;
      end while (waitp && (k <= stalls));
    end
    if (ph.size() > 2) model_cnt = model_cnt + 1'b1;
  endtask

  typedef struct {
    logic [5:0] op;
    int         fs;
    int         ms;
    int         cyc;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int cyc, st, n, sel;
    logic [5:0] op;

    vecs[0] = '{6'b000000, 0, 0, 4};
    vecs[1] = '{6'b100011, 0, 2, 7};
    vecs[2] = '{6'b101011, 0, 0, 4};
    vecs[3] = '{6'b000100, 0, 0, 3};
    vecs[4] = '{6'b111111, 0, 0, 2};
    vecs[5] = '{6'b000010, 0, 0, JUMP_EN ? 3 : 2};
    vecs[6] = '{6'b100011, 1, 0, 6};
    vecs[7] = '{6'b101011, 0, 3, 7};

    rst_n = 1'b0; opcode = 6'b0; zero = 1'b0; mem_ready = 1'b0; model_cnt = '0;
    @(posedge clk); #1;
    check("reset_state", 32'(state), 32'd0);
    check("reset_ctrl", 32'(ctrl_v), 32'd0);
    check("reset_count", 32'(instr_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_to_fetch", 32'(state), 32'd1);

    foreach (vecs[i]) begin
      run_instr(vecs[i].op, vecs[i].fs, vecs[i].ms, cyc, st);
      check("cpi_directed", 32'(cyc), 32'(vecs[i].cyc));
    end
    check("count_directed", 32'(instr_count), 32'(model_cnt));

    // Reset asserted while a load is stalled in MEMRD.
    opcode = 6'b100011;
    mem_ready = 1'b1;
    n = 0;
    while ((state != 4'd4) && (n < 10)) begin
      @(posedge clk); #1;
      n++;
    end
    check("reach_memrd", 32'(state), 32'd4);
    mem_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_state", 32'(state), 32'd0);
    check("abort_ctrl", 32'(ctrl_v), 32'd0);
    check("abort_count", 32'(instr_count), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("held_ctrl", 32'(ctrl_v), 32'd0);
    rst_n = 1'b1;
    model_cnt = '0;
    @(posedge clk); #1;
    check("release_fetch", 32'(state), 32'd1);

    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 5);
      case (sel)
        0: op = 6'b000000;
        1: op = 6'b100011;
        2: op = 6'b101011;
        3: op = 6'b000100;
        4: op = 6'b000010;
        default: op = 6'($urandom_range(0, 63));
      endcase
      run_instr(op, -1, -1, cyc, st);
      check("cpi_random", 32'(cyc), 32'(base_cpi(op) + st));
    end
    check("count_final", 32'(instr_count), 32'(model_cnt));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
